// File: rtl/pipe_pkg.sv
// Shared pipeline types: default widths and the EX-stage control bundle.
// Pure declarations; no latency or flow control of its own.
// Used by idex_reg and exmem_reg so that bubble encoding stays in one place.
package pipe_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_ALUOP_W = 3;

    typedef struct packed {
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem_to_reg;
        logic                   alu_src;
        logic [DEF_ALUOP_W-1:0] alu_op;
    } idex_ctrl_t;

    // A bubble must never write the register file or touch memory.
    localparam idex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector for the ID stage against the load sitting in EX.
// Latency: purely combinational, same cycle.
// Backpressure: stall holds IF/ID and PC; a concurrent flush suppresses it.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             idex_valid,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_wr_reg,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             flush,
    output logic             hazard,
    output logic             stall
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (idex_wr_reg == id_rs);
    // rt only matters when the instruction actually reads it as a source.
    assign rt_match = id_uses_rt & (idex_wr_reg == id_rt);

    assign hazard = idex_valid & idex_mem_read & (idex_wr_reg != '0) &
                    id_valid & (rs_match | rt_match);

    // A killed instruction must not be held, so flush wins over stall.
    assign stall = hazard & ~flush;

endmodule

// File: rtl/idex_reg.sv
// ID/EX pipeline register with WB->ID bypass, RegDst selection and load-use bubbling.
// Latency: one cycle from id_* to IDEX_*; stall is combinational.
// Backpressure: on hazard or flush a bubble is latched; stall tells IF/ID to hold.
module idex_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int ALUOP_W = DEF_ALUOP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_uses_rt,
    input  logic [DATA_W-1:0]  id_rData1,
    input  logic [DATA_W-1:0]  id_rData2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_RegWrite,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_MemToReg,
    input  logic               id_ALUSrc,
    input  logic               id_RegDst,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic               flush,
    input  logic               MEMWB_RegWrite,
    input  logic [REG_W-1:0]   MEMWB_rd,
    input  logic [DATA_W-1:0]  wData,
    output logic               stall,
    output logic               IDEX_valid,
    output logic [REG_W-1:0]   IDEX_rs,
    output logic [REG_W-1:0]   IDEX_rt,
    output logic [REG_W-1:0]   IDEX_wr_reg,
    output logic [DATA_W-1:0]  IDEX_rData1,
    output logic [DATA_W-1:0]  IDEX_rData2,
    output logic [DATA_W-1:0]  IDEX_imm,
    output logic               IDEX_RegWrite,
    output logic               IDEX_MemRead,
    output logic               IDEX_MemWrite,
    output logic               IDEX_MemToReg,
    output logic               IDEX_ALUSrc,
    output logic [ALUOP_W-1:0] IDEX_ALUOp
);

    logic              hazard;
    logic              bubble;
    logic              byp1;
    logic              byp2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    idex_ctrl_t        id_ctrl;

    logic              valid_q;
    logic [REG_W-1:0]  rs_q;
    logic [REG_W-1:0]  rt_q;
    logic [REG_W-1:0]  wr_reg_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;
    logic [DATA_W-1:0] imm_q;
    idex_ctrl_t        ctrl_q;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard (
        .idex_valid    (valid_q),
        .idex_mem_read (ctrl_q.mem_read),
        .idex_wr_reg   (wr_reg_q),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .flush         (flush),
        .hazard        (hazard),
        .stall         (stall)
    );

    assign bubble = flush | hazard;

    // The register file is written at the end of this cycle, so the read ports still show stale data.
    assign byp1 = MEMWB_RegWrite & (MEMWB_rd != '0) & (MEMWB_rd == id_rs);
    assign byp2 = MEMWB_RegWrite & (MEMWB_rd != '0) & (MEMWB_rd == id_rt);
    assign op1  = byp1 ? wData : id_rData1;
    assign op2  = byp2 ? wData : id_rData2;

    assign id_ctrl = '{
        reg_write:  id_RegWrite,
        mem_read:   id_MemRead,
        mem_write:  id_MemWrite,
        mem_to_reg: id_MemToReg,
        alu_src:    id_ALUSrc,
        alu_op:     id_ALUOp
    };

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            wr_reg_q <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            ctrl_q   <= BUBBLE_CTRL;
        end else begin
            // Datapath fields load unconditionally; valid and control alone define a bubble.
            valid_q  <= id_valid & ~bubble;
            rs_q     <= id_rs;
            rt_q     <= id_rt;
            wr_reg_q <= id_RegDst ? id_rd : id_rt;
            rdata1_q <= op1;
            rdata2_q <= op2;
            imm_q    <= id_imm;
            ctrl_q   <= (bubble | ~id_valid) ? BUBBLE_CTRL : id_ctrl;
        end
    end

    assign IDEX_valid    = valid_q;
    assign IDEX_rs       = rs_q;
    assign IDEX_rt       = rt_q;
    assign IDEX_wr_reg   = wr_reg_q;
    assign IDEX_rData1   = rdata1_q;
    assign IDEX_rData2   = rdata2_q;
    assign IDEX_imm      = imm_q;
    assign IDEX_RegWrite = ctrl_q.reg_write;
    assign IDEX_MemRead  = ctrl_q.mem_read;
    assign IDEX_MemWrite = ctrl_q.mem_write;
    assign IDEX_MemToReg = ctrl_q.mem_to_reg;
    assign IDEX_ALUSrc   = ctrl_q.alu_src;
    assign IDEX_ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_idex_reg.sv
// Table-driven bench for idex_reg with an expected-result queue.
module tb_idex_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt;
    logic [31:0] id_rData1, id_rData2, id_imm;
    logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc, id_RegDst;
    logic [2:0]  id_ALUOp;
    logic        flush;
    logic        MEMWB_RegWrite;
    logic [4:0]  MEMWB_rd;
    logic [31:0] wData;
    logic        stall;
    logic        IDEX_valid;
    logic [4:0]  IDEX_rs, IDEX_rt, IDEX_wr_reg;
    logic [31:0] IDEX_rData1, IDEX_rData2, IDEX_imm;
    logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUSrc;
    logic [2:0]  IDEX_ALUOp;

    idex_reg dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rData1(id_rData1), .id_rData2(id_rData2),
        .id_imm(id_imm), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_MemToReg(id_MemToReg), .id_ALUSrc(id_ALUSrc),
        .id_RegDst(id_RegDst), .id_ALUOp(id_ALUOp), .flush(flush),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_rd(MEMWB_rd), .wData(wData), .stall(stall),
        .IDEX_valid(IDEX_valid), .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt), .IDEX_wr_reg(IDEX_wr_reg),
        .IDEX_rData1(IDEX_rData1), .IDEX_rData2(IDEX_rData2), .IDEX_imm(IDEX_imm),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
        .IDEX_MemToReg(IDEX_MemToReg), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_ALUOp(IDEX_ALUOp)
    );

    always #5 clk = ~clk;

    // ctl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc}
    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic        urt;
        logic [31:0] d1, d2, imm;
        logic [4:0]  ctl;
        logic        regdst;
        logic [2:0]  aluop;
        logic        flush;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wdata;
    } in_t;

    typedef struct {
        logic        stall;
        logic        full;
        logic        v;
        logic [4:0]  rs, rt, wr;
        logic [31:0] d1, d2, imm;
        logic [4:0]  ctl;
        logic [2:0]  aluop;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    vec_t tbl[12];

    function automatic in_t mi(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic urt, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] ctl,
                               input logic regdst, input logic [2:0] aluop, input logic fl,
                               input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        in_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.rd = rd; r.urt = urt;
        r.d1 = d1; r.d2 = d2; r.imm = imm; r.ctl = ctl; r.regdst = regdst;
        r.aluop = aluop; r.flush = fl; r.wb_we = we; r.wb_rd = wrd; r.wdata = wd;
        return r;
    endfunction

    function automatic exp_t me(input logic st, input logic full, input logic v,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                input logic [4:0] ctl, input logic [2:0] aluop);
        exp_t r;
        r.stall = st; r.full = full; r.v = v; r.rs = rs; r.rt = rt; r.wr = wr;
        r.d1 = d1; r.d2 = d2; r.imm = imm; r.ctl = ctl; r.aluop = aluop;
        return r;
    endfunction

    function automatic exp_t bub(input logic st);
        return me(st, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'b00000, 3'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic apply(input in_t i);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_uses_rt = i.urt;
        id_rData1 = i.d1; id_rData2 = i.d2; id_imm = i.imm;
        {id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc} = i.ctl;
        id_RegDst = i.regdst; id_ALUOp = i.aluop; flush = i.flush;
        MEMWB_RegWrite = i.wb_we; MEMWB_rd = i.wb_rd; wData = i.wdata;
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".valid"},    32'(IDEX_valid),    32'(e.v));
        chk({tag, ".RegWrite"}, 32'(IDEX_RegWrite), 32'(e.ctl[4]));
        chk({tag, ".MemRead"},  32'(IDEX_MemRead),  32'(e.ctl[3]));
        chk({tag, ".MemWrite"}, 32'(IDEX_MemWrite), 32'(e.ctl[2]));
        if (e.full) begin
            chk({tag, ".rs"},       32'(IDEX_rs),       32'(e.rs));
            chk({tag, ".rt"},       32'(IDEX_rt),       32'(e.rt));
            chk({tag, ".wr_reg"},   32'(IDEX_wr_reg),   32'(e.wr));
            chk({tag, ".rData1"},   IDEX_rData1,        e.d1);
            chk({tag, ".rData2"},   IDEX_rData2,        e.d2);
            chk({tag, ".imm"},      IDEX_imm,           e.imm);
            chk({tag, ".MemToReg"}, 32'(IDEX_MemToReg), 32'(e.ctl[1]));
            chk({tag, ".ALUSrc"},   32'(IDEX_ALUSrc),   32'(e.ctl[0]));
            chk({tag, ".ALUOp"},    32'(IDEX_ALUOp),    32'(e.aluop));
        end
    endtask

    // Called just after a rising edge: present inputs, check stall, clock, check latched result.
    task automatic drive(input string tag, input in_t i, input exp_t e);
        exp_t got;
        apply(i);
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(e.stall));
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = exp_q.pop_front();
            check_out(tag, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // lw to r5: ctl = RegWrite|MemRead|MemToReg|ALUSrc
        in_t lw5;
        in_t add5;
        lw5  = mi(1, 5'd1, 5'd5, 5'd0, 0, 32'h100, 32'h200, 32'h8, 5'b11011, 0, 3'd0, 0, 0, 5'd0, 32'd0);
        add5 = mi(1, 5'd5, 5'd6, 5'd7, 1, 32'hA, 32'hB, 32'h0, 5'b10000, 1, 3'd2, 0, 0, 5'd0, 32'd0);

        tbl[0]  = '{mi(1, 5'd3, 5'd4, 5'd9, 1, 32'h11, 32'h22, 32'h5, 5'b10000, 1, 3'd2, 0, 0, 5'd0, 32'd0),
                    me(0, 1, 1, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'h5, 5'b10000, 3'd2)};
        tbl[1]  = '{mi(1, 5'd3, 5'd4, 5'd9, 1, 32'h11, 32'h22, 32'h6, 5'b10001, 0, 3'd0, 0, 0, 5'd0, 32'd0),
                    me(0, 1, 1, 5'd3, 5'd4, 5'd4, 32'h11, 32'h22, 32'h6, 5'b10001, 3'd0)};
        tbl[2]  = '{mi(1, 5'd1, 5'd7, 5'd2, 1, 32'h33, 32'h0, 32'h0, 5'b10000, 1, 3'd1, 0, 1, 5'd7, 32'hDEADBEEF),
                    me(0, 1, 1, 5'd1, 5'd7, 5'd2, 32'h33, 32'hDEADBEEF, 32'h0, 5'b10000, 3'd1)};
        tbl[3]  = '{mi(1, 5'd1, 5'd7, 5'd2, 1, 32'h33, 32'h0, 32'h0, 5'b10000, 1, 3'd1, 0, 1, 5'd0, 32'hDEADBEEF),
                    me(0, 1, 1, 5'd1, 5'd7, 5'd2, 32'h33, 32'h0, 32'h0, 5'b10000, 3'd1)};
        tbl[4]  = '{mi(1, 5'd1, 5'd0, 5'd2, 1, 32'h33, 32'h0, 32'h0, 5'b10000, 1, 3'd1, 0, 1, 5'd0, 32'hDEADBEEF),
                    me(0, 1, 1, 5'd1, 5'd0, 5'd2, 32'h33, 32'h0, 32'h0, 5'b10000, 3'd1)};
        tbl[5]  = '{mi(1, 5'd12, 5'd13, 5'd2, 1, 32'h1, 32'h44, 32'h10, 5'b00101, 0, 3'd0, 0, 1, 5'd12, 32'hCAFE0001),
                    me(0, 1, 1, 5'd12, 5'd13, 5'd13, 32'hCAFE0001, 32'h44, 32'h10, 5'b00101, 3'd0)};
        tbl[6]  = '{mi(1, 5'd12, 5'd13, 5'd2, 1, 32'h1, 32'h44, 32'h10, 5'b00101, 0, 3'd0, 0, 0, 5'd12, 32'hCAFE0001),
                    me(0, 1, 1, 5'd12, 5'd13, 5'd13, 32'h1, 32'h44, 32'h10, 5'b00101, 3'd0)};
        tbl[7]  = '{mi(0, 5'd2, 5'd3, 5'd4, 1, 32'h1, 32'h2, 32'h3, 5'b11100, 1, 3'd5, 0, 0, 5'd0, 32'd0),
                    me(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'b00000, 3'd0)};
        tbl[8]  = '{lw5, me(0, 1, 1, 5'd1, 5'd5, 5'd5, 32'h100, 32'h200, 32'h8, 5'b11011, 3'd0)};
        tbl[9]  = '{mi(1, 5'd2, 5'd5, 5'd0, 0, 32'h7, 32'h9, 32'h3, 5'b10001, 0, 3'd0, 0, 0, 5'd0, 32'd0),
                    me(0, 1, 1, 5'd2, 5'd5, 5'd5, 32'h7, 32'h9, 32'h3, 5'b10001, 3'd0)};
        tbl[10] = '{mi(1, 5'd1, 5'd0, 5'd0, 0, 32'h1, 32'h2, 32'h4, 5'b11011, 0, 3'd0, 0, 0, 5'd0, 32'd0),
                    me(0, 1, 1, 5'd1, 5'd0, 5'd0, 32'h1, 32'h2, 32'h4, 5'b11011, 3'd0)};
        tbl[11] = '{mi(1, 5'd0, 5'd3, 5'd4, 1, 32'h0, 32'h5, 32'h0, 5'b10000, 1, 3'd2, 0, 0, 5'd0, 32'd0),
                    me(0, 1, 1, 5'd0, 5'd3, 5'd4, 32'h0, 32'h5, 32'h0, 5'b10000, 3'd2)};

        // Reset with random ID inputs
        reset = 1'b1;
        apply(mi(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, $urandom, $urandom, $urandom,
                 5'($urandom), 1'($urandom), 3'($urandom), 1'b0, 1'b1, 5'($urandom), $urandom));
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", me(0, 1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'b00000, 3'd0));
        chk("reset.stall", 32'(stall), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 12; k++)
            drive($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);

        // Load-use on rs: one stall, bubble, then the add is latched
        drive("lu.lw", lw5, me(0, 1, 1, 5'd1, 5'd5, 5'd5, 32'h100, 32'h200, 32'h8, 5'b11011, 3'd0));
        drive("lu.hold", add5, bub(1));
        drive("lu.add", add5, me(0, 1, 1, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'h0, 5'b10000, 3'd2));

        // Load-use on rt
        drive("lurt.lw", mi(1, 5'd1, 5'd8, 5'd0, 0, 32'h1, 32'h2, 32'h0, 5'b11011, 0, 3'd0, 0, 0, 5'd0, 32'd0),
              me(0, 1, 1, 5'd1, 5'd8, 5'd8, 32'h1, 32'h2, 32'h0, 5'b11011, 3'd0));
        drive("lurt.hold", mi(1, 5'd1, 5'd8, 5'd9, 1, 32'h3, 32'h4, 32'h0, 5'b10000, 1, 3'd2, 0, 0, 5'd0, 32'd0),
              bub(1));

        // Flush together with hazard: no stall, bubble latched
        drive("fh.lw", lw5, me(0, 1, 1, 5'd1, 5'd5, 5'd5, 32'h100, 32'h200, 32'h8, 5'b11011, 3'd0));
        drive("fh.flush", mi(1, 5'd5, 5'd6, 5'd7, 1, 32'hA, 32'hB, 32'h0, 5'b10100, 1, 3'd2, 1, 0, 5'd0, 32'd0),
              bub(0));
        drive("fh.next", add5, me(0, 1, 1, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'h0, 5'b10000, 3'd2));

        // Back-to-back dependent loads: each dependent instruction stalls once
        drive("bb.lw5", lw5, me(0, 1, 1, 5'd1, 5'd5, 5'd5, 32'h100, 32'h200, 32'h8, 5'b11011, 3'd0));
        drive("bb.lw6h", mi(1, 5'd5, 5'd6, 5'd0, 0, 32'h0, 32'h0, 32'h4, 5'b11011, 0, 3'd0, 0, 0, 5'd0, 32'd0),
              bub(1));
        drive("bb.lw6", mi(1, 5'd5, 5'd6, 5'd0, 0, 32'h0, 32'h0, 32'h4, 5'b11011, 0, 3'd0, 0, 0, 5'd0, 32'd0),
              me(0, 1, 1, 5'd5, 5'd6, 5'd6, 32'h0, 32'h0, 32'h4, 5'b11011, 3'd0));
        drive("bb.addh", mi(1, 5'd6, 5'd2, 5'd3, 1, 32'h5, 32'h6, 32'h0, 5'b10000, 1, 3'd2, 0, 0, 5'd0, 32'd0),
              bub(1));
        drive("bb.add", mi(1, 5'd6, 5'd2, 5'd3, 1, 32'h5, 32'h6, 32'h0, 5'b10000, 1, 3'd2, 0, 0, 5'd0, 32'd0),
              me(0, 1, 1, 5'd6, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0, 5'b10000, 3'd2));

        // Reset asserted mid-stall
        drive("rs.lw", lw5, me(0, 1, 1, 5'd1, 5'd5, 5'd5, 32'h100, 32'h200, 32'h8, 5'b11011, 3'd0));
        apply(add5);
        #1;
        chk("rs.stall_before", 32'(stall), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_out("rs.after", me(0, 1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'b00000, 3'd0));
        chk("rs.stall_after", 32'(stall), 32'd0);
        reset = 1'b0;
        drive("rs.resume", add5, me(0, 1, 1, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'h0, 5'b10000, 3'd2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
